// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for mem_port_arbiter and its owner tracker.
//   arb_owner_e           : which requester issued a transaction.
//   arb_state_e           : arbiter FSM states.
//   MAX_OUTSTANDING_LIMIT : upper bound on tracker depth.
package mem_arb_pkg;
  typedef enum logic {
    ARB_INSTR = 1'b0,
    ARB_DATA  = 1'b1
  } arb_owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_I = 2'd1,
    ARB_LOCK_D = 2'd2
  } arb_state_e;

  localparam int unsigned MAX_OUTSTANDING_LIMIT = 8;
endpackage

// File: rtl/riscv_defines.sv
// riscv_defines: core-wide constants shared by the memory-side blocks.
//   WORD_WIDTH : address/data word width of the core.
package riscv_defines;
  localparam int unsigned WORD_WIDTH = 32;
endpackage

// File: rtl/arb_owner_fifo.sv
// arb_owner_fifo: in-order tracker of owner IDs for granted transactions.
//   clk, rst  : rising-edge clock, synchronous active-high reset (flushes).
//   i_push    : record i_owner (ignored when full unless popping too).
//   i_pop     : drop head entry (ignored when empty).
//   o_owner   : head entry.
//   o_count   : number of stored entries.
//   o_full    : o_count == DEPTH.
//   o_empty   : o_count == 0.
module arb_owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  arb_owner_e i_owner,
  input  logic       i_pop,
  output arb_owner_e o_owner,
  output logic [3:0] o_count,
  output logic       o_full,
  output logic       o_empty
);
  localparam logic [2:0] LAST    = 3'(DEPTH - 1);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  arb_owner_e r_mem [MAX_OUTSTANDING_LIMIT];
  logic [2:0] r_wr_ptr;
  logic [2:0] r_rd_ptr;
  logic [3:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign o_full  = (r_count == DEPTH_C);
  assign o_empty = (r_count == 4'd0);
  assign o_count = r_count;
  assign o_owner = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_owner;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? 3'd0 : r_wr_ptr + 3'd1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? 3'd0 : r_rd_ptr + 3'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/gnt/rvalid memory port between the
// instruction-fetch and data interfaces of the core. Owners of granted
// transactions are tracked in order so responses return to their issuer.
//   clk, rst           : rising-edge clock, synchronous active-high reset.
//   instr_*            : fetch request/grant/response.
//   data_*             : load/store request/grant/response.
//   mem_*              : shared memory port (request side combinational).
//   arb_err_o          : sticky, set by mem_rvalid_i with nothing outstanding.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin between
// simultaneous requesters; otherwise data has fixed priority over instr.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORD_WIDTH      = riscv_defines::WORD_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  input  logic [WORD_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [WORD_WIDTH-1:0] instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [WORD_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [WORD_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [WORD_WIDTH-1:0] data_rdata_o,
  output logic                  mem_req_o,
  output logic [WORD_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [WORD_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [WORD_WIDTH-1:0] mem_rdata_i,
  output logic                  arb_err_o
);
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  arb_state_e r_state;
  logic       r_arb_err;
  arb_owner_e w_winner;
  arb_owner_e w_owner;
  arb_owner_e w_head;
  logic       w_mem_req;
  logic       w_grant;
  logic       w_pop;
  logic       w_can_issue;
  logic [3:0] w_count;
  logic       w_full;
  logic       w_empty;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner_e r_rr_ptr;

  always_comb begin
    w_winner = ARB_INSTR;
    if (instr_req_i && data_req_i) w_winner = r_rr_ptr;
    else if (data_req_i)           w_winner = ARB_DATA;
  end

  // Pointer moves to the side opposite the one just granted.
  always_ff @(posedge clk) begin
    if (rst)          r_rr_ptr <= ARB_INSTR;
    else if (w_grant) r_rr_ptr <= (w_owner == ARB_DATA) ? ARB_INSTR : ARB_DATA;
  end
`else
  always_comb begin
    w_winner = data_req_i ? ARB_DATA : ARB_INSTR;
  end
`endif

  // Issue gating uses the registered count only, so a same-cycle rvalid
  // cannot reopen the port while the tracker is at its limit.
  assign w_can_issue = (w_count < MAX_CNT);

  always_comb begin
    w_owner   = w_winner;
    w_mem_req = 1'b0;
    case (r_state)
      ARB_LOCK_I: begin
        w_owner   = ARB_INSTR;
        w_mem_req = w_can_issue & instr_req_i;
      end
      ARB_LOCK_D: begin
        w_owner   = ARB_DATA;
        w_mem_req = w_can_issue & data_req_i;
      end
      default: begin
        w_owner   = w_winner;
        w_mem_req = w_can_issue & (instr_req_i | data_req_i);
      end
    endcase
    if (rst) w_mem_req = 1'b0;
  end

  assign w_grant = w_mem_req & mem_gnt_i;
  assign w_pop   = mem_rvalid_i & ~w_empty & ~rst;

  assign mem_req_o   = w_mem_req;
  assign mem_addr_o  = !w_mem_req ? '0 : (w_owner == ARB_DATA) ? data_addr_i : instr_addr_i;
  assign mem_we_o    = w_mem_req & (w_owner == ARB_DATA) & data_we_i;
  assign mem_be_o    = !w_mem_req ? '0 : (w_owner == ARB_DATA) ? data_be_i : '1;
  assign mem_wdata_o = (w_mem_req && w_owner == ARB_DATA) ? data_wdata_i : '0;

  assign instr_gnt_o    = w_grant & (w_owner == ARB_INSTR);
  assign data_gnt_o     = w_grant & (w_owner == ARB_DATA);
  assign instr_rvalid_o = w_pop & (w_head == ARB_INSTR);
  assign data_rvalid_o  = w_pop & (w_head == ARB_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign arb_err_o      = r_arb_err;

  arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_grant & ~w_full),
    .i_owner (w_owner),
    .i_pop   (w_pop),
    .o_owner (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A dropped request while locked is a protocol violation: release the lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      case (r_state)
        ARB_IDLE:
          if (w_mem_req && !mem_gnt_i)
            r_state <= (w_owner == ARB_DATA) ? ARB_LOCK_D : ARB_LOCK_I;
        ARB_LOCK_I:
          if (w_grant || !instr_req_i) r_state <= ARB_IDLE;
        ARB_LOCK_D:
          if (w_grant || !data_req_i) r_state <= ARB_IDLE;
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          r_arb_err <= 1'b0;
    else if (mem_rvalid_i && w_empty) r_arb_err <= 1'b1;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations for
// mem_port_arbiter (MAX_OUTSTANDING = 2). Inputs change on the falling edge;
// outputs are sampled 1 time unit later.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        arb_err_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WORD_WIDTH      (32),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .arb_err_o      (arb_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = '0;
    data_req_i   = 1'b0;
    data_addr_i  = '0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_wdata_i = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  // Returns at the falling edge with all inputs idle.
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    do_reset();

    // Reset state
    mem_rdata_i = 32'h1234_5678;
    #1;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_arb_err", 32'(arb_err_o), 32'd0);
    chk("rst_gnts", 32'({instr_gnt_o, data_gnt_o}), 32'd0);
    chk("rst_rvalids", 32'({instr_rvalid_o, data_rvalid_o}), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_irdata", instr_rdata_o, 32'h1234_5678);
    chk("rst_drdata", data_rdata_o, 32'h1234_5678);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Both requesting, granted every cycle: I, D, I, D, I, D
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      instr_req_i = 1'b1; instr_addr_i = 32'h0000_0100;
      data_req_i  = 1'b1; data_addr_i  = 32'h0000_3000;
      mem_gnt_i   = 1'b1;
      mem_rvalid_i = (k != 0);
      #1;
      chk("rr_igrant", 32'(instr_gnt_o), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_dgrant", 32'(data_gnt_o),  (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k != 0) chk("rr_drvalid", 32'(data_rvalid_o), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    clear_inputs();
    mem_rvalid_i = 1'b1;
    #1;
    chk("rr_drain_drvalid", 32'(data_rvalid_o), 32'd1);
`else
    // Both requesting, granted every cycle: data first, then instr
    @(negedge clk);
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0100;
    data_req_i  = 1'b1; data_addr_i  = 32'h0000_2000;
    mem_gnt_i   = 1'b1;
    #1;
    chk("both_addr0", mem_addr_o, 32'h0000_2000);
    chk("both_dgnt0", 32'(data_gnt_o), 32'd1);
    chk("both_ignt0", 32'(instr_gnt_o), 32'd0);
    @(negedge clk);
    data_req_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA_0001;
    #1;
    chk("both_addr1", mem_addr_o, 32'h0000_0100);
    chk("both_ignt1", 32'(instr_gnt_o), 32'd1);
    chk("both_drvalid1", 32'(data_rvalid_o), 32'd1);
    chk("both_irvalid1", 32'(instr_rvalid_o), 32'd0);
    chk("both_drdata1", data_rdata_o, 32'hAAAA_0001);
    @(negedge clk);
    instr_req_i = 1'b0; mem_gnt_i = 1'b0;
    mem_rdata_i = 32'hBBBB_0002;
    #1;
    chk("both_irvalid2", 32'(instr_rvalid_o), 32'd1);
    chk("both_drvalid2", 32'(data_rvalid_o), 32'd0);
    chk("both_irdata2", instr_rdata_o, 32'hBBBB_0002);
    chk("both_req2", 32'(mem_req_o), 32'd0);
`endif

    // Lock on instr while grant held low; data arrives but must wait
    @(negedge clk);
    clear_inputs();
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0100;
    #1;
    chk("lock_addr0", mem_addr_o, 32'h0000_0100);
    chk("lock_ignt0", 32'(instr_gnt_o), 32'd0);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      data_req_i = 1'b1; data_addr_i = 32'h0000_3000;
      #1;
      chk("lock_addr_hold", mem_addr_o, 32'h0000_0100);
      chk("lock_dgnt_hold", 32'(data_gnt_o), 32'd0);
    end
    @(negedge clk);
    mem_gnt_i = 1'b1;
    #1;
    chk("lock_addr3", mem_addr_o, 32'h0000_0100);
    chk("lock_ignt3", 32'(instr_gnt_o), 32'd1);
    chk("lock_dgnt3", 32'(data_gnt_o), 32'd0);
    @(negedge clk);
    instr_req_i = 1'b0;
    #1;
    chk("lock_addr4", mem_addr_o, 32'h0000_3000);
    chk("lock_dgnt4", 32'(data_gnt_o), 32'd1);
    @(negedge clk);
    clear_inputs();
    mem_rvalid_i = 1'b1;
    #1;
    chk("lock_irvalid5", 32'(instr_rvalid_o), 32'd1);
    @(negedge clk);
    #1;
    chk("lock_drvalid6", 32'(data_rvalid_o), 32'd1);
    chk("lock_irvalid6", 32'(instr_rvalid_o), 32'd0);

    // Outstanding limit of 2
    @(negedge clk);
    clear_inputs();
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0200; mem_gnt_i = 1'b1;
    #1;
    chk("max_ignt0", 32'(instr_gnt_o), 32'd1);
    @(negedge clk);
    #1;
    chk("max_ignt1", 32'(instr_gnt_o), 32'd1);
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    #1;
    chk("max_req_full", 32'(mem_req_o), 32'd0);
    chk("max_ignt_full", 32'(instr_gnt_o), 32'd0);
    chk("max_irvalid2", 32'(instr_rvalid_o), 32'd1);
    @(negedge clk);
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
    #1;
    chk("max_req_reopen", 32'(mem_req_o), 32'd1);
    @(negedge clk);
    instr_req_i = 1'b0;
    #1;
    chk("drop_req", 32'(mem_req_o), 32'd0);
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    #1;
    chk("max_irvalid_drain", 32'(instr_rvalid_o), 32'd1);

    // Store
    @(negedge clk);
    clear_inputs();
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
    data_addr_i = 32'h0000_2000; data_wdata_i = 32'hDEAD_BEEF;
    mem_gnt_i = 1'b1;
    #1;
    chk("st_we", 32'(mem_we_o), 32'd1);
    chk("st_be", 32'(mem_be_o), 32'h3);
    chk("st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("st_addr", mem_addr_o, 32'h0000_2000);
    chk("st_dgnt", 32'(data_gnt_o), 32'd1);
    @(negedge clk);
    clear_inputs();
    mem_rvalid_i = 1'b1;
    #1;
    chk("st_drvalid", 32'(data_rvalid_o), 32'd1);
    chk("st_irvalid", 32'(instr_rvalid_o), 32'd0);

    // Stray rvalid with empty tracker
    @(negedge clk);
    #1;
    chk("err_no_irvalid", 32'(instr_rvalid_o), 32'd0);
    chk("err_no_drvalid", 32'(data_rvalid_o), 32'd0);
    chk("err_not_yet", 32'(arb_err_o), 32'd0);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1;
    chk("err_set", 32'(arb_err_o), 32'd1);
    @(negedge clk);
    #1;
    chk("err_sticky", 32'(arb_err_o), 32'd1);
    do_reset();
    #1;
    chk("err_cleared", 32'(arb_err_o), 32'd0);

    // Reset with a transaction outstanding; its late rvalid is an error
    @(negedge clk);
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0400; mem_gnt_i = 1'b1;
    #1;
    chk("flush_ignt", 32'(instr_gnt_o), 32'd1);
    do_reset();
    mem_rvalid_i = 1'b1;
    #1;
    chk("flush_no_irvalid", 32'(instr_rvalid_o), 32'd0);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1;
    chk("flush_err", 32'(arb_err_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one external req/gnt/rvalid memory port between the core's instruction-fetch interface and its data (load/store) interface. Sits between the core and the single-ported SoC memory. Each granted transaction's owner is recorded in an in-order tracker so that every mem_rvalid_i is routed back to the requester that issued it. Fixed priority is data over instruction; round-robin is available as a compile-time option.

Parameters:
WORD_WIDTH, 32, address/data width; taken from riscv_defines.
MAX_OUTSTANDING, 2, granted-but-unanswered transactions allowed; legal range 1..8.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  synchronous, active-high reset.
instr_req_i  in  1  fetch request.
instr_addr_i  in  WORD_WIDTH  fetch address.
instr_gnt_o  out  1  fetch request accepted.
instr_rvalid_o  out  1  fetch response valid.
instr_rdata_o  out  WORD_WIDTH  fetch read data.
data_req_i  in  1  load/store request.
data_addr_i  in  WORD_WIDTH  load/store address.
data_we_i  in  1  1 = store.
data_be_i  in  4  byte enables.
data_wdata_i  in  WORD_WIDTH  store data.
data_gnt_o  out  1  load/store accepted.
data_rvalid_o  out  1  load/store response valid.
data_rdata_o  out  WORD_WIDTH  load read data.
mem_req_o  out  1  memory request.
mem_addr_o  out  WORD_WIDTH  memory address.
mem_we_o  out  1  memory write enable.
mem_be_o  out  4  memory byte enables.
mem_wdata_o  out  WORD_WIDTH  memory write data.
mem_gnt_i  in  1  memory accepted the request.
mem_rvalid_i  in  1  memory response valid; one per granted request, including stores.
mem_rdata_i  in  WORD_WIDTH  memory read data.
arb_err_o  out  1  sticky: mem_rvalid_i arrived with no transaction outstanding.

Behaviour:
- Reset: state IDLE, outstanding count 0, tracker empty, round-robin pointer = instr, arb_err_o = 0. All outputs are 0 except rdata, which follows mem_rdata_i.
- FSM states:
  - IDLE: no pending, ungranted mem_req_o.
  - LOCK_I: instr request presented but not yet granted.
  - LOCK_D: data request presented but not yet granted.
- Issuing is allowed only when count < MAX_OUTSTANDING. When count == MAX_OUTSTANDING, mem_req_o = 0, even if mem_rvalid_i is high in the same cycle.
- In IDLE with issuing allowed:
  - Winner is data if data_req_i, else instr.
  - mem_* is driven combinationally from the winner in the same cycle.
  - If mem_gnt_i is high, raise the winner's x_gnt_o combinationally, push the owner ID, and stay in IDLE.
  - If mem_gnt_i is low, go to LOCK_I or LOCK_D for the winner.
- In LOCK_x: mem_* is driven from x only; no re-arbitration, even if a higher-priority request appears. Return to IDLE on mem_gnt_i.
- Requester dropping req while in LOCK_x is a protocol violation; the arbiter deasserts mem_req_o and returns to IDLE.
- Grant path is zero-latency: x_gnt_o = mem_gnt_i & mem_req_o & (owner == x).
- Response routing:
  - On mem_rvalid_i, pop the tracker head and assert the matching x_rvalid_o in the same cycle.
  - instr_rdata_o and data_rdata_o both equal mem_rdata_i.
  - Responses are strictly in order.
- Same-cycle push (grant) and pop (rvalid): count is unchanged.
- mem_rvalid_i with count 0: no x_rvalid_o, arb_err_o set until rst.
- Reset mid-transaction: tracker flushed; later rvalids for flushed transactions set arb_err_o.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both requesters request in IDLE, the winner is the side the pointer indicates. After each grant the pointer flips to the other side. A lone requester always wins.
- Undefined: fixed data-over-instr priority; the pointer register is not generated.

Decomposition:
- Shared package mem_arb_pkg:
  - arb_owner_e {ARB_INSTR, ARB_DATA}.
  - arb_state_e {ARB_IDLE, ARB_LOCK_I, ARB_LOCK_D}.
  - MAX_OUTSTANDING_LIMIT = 8.
- WORD_WIDTH comes from riscv_defines.
- Sub-module arb_owner_fifo: synchronous FIFO of 1-bit owner IDs, depth MAX_OUTSTANDING. Push and pop are allowed in the same cycle; it exports count, full and empty.

Test Plan:
- Both requesting, mem_gnt_i = 1 every cycle, feature off: data granted first, instr next cycle. rvalids 1 cycle after grant route data → data_rvalid_o, then instr → instr_rvalid_o.
- Same case with MEM_ARB_ROUND_ROBIN_EN, 6 cycles of both requesting: grants alternate I, D, I, D, I, D starting from instr.
- instr presented, mem_gnt_i held 0 for 3 cycles while data_req_i rises at cycle 1: mem_addr_o stays instr_addr_i (e.g. 0x0000_0100) until the grant, then data is granted next.
- MAX_OUTSTANDING = 2, no rvalid: after 2 grants mem_req_o = 0. One rvalid restores mem_req_o the next cycle.
- Store 0xDEAD_BEEF, be = 4'b0011, to 0x0000_2000: mem_we_o = 1, mem_be_o = 0011, mem_wdata_o = 0xDEAD_BEEF. Its rvalid pulses data_rvalid_o.
- rvalid with empty tracker: arb_err_o = 1 and stays 1; no x_rvalid_o; rst clears it.
